// File: rtl/icache_responder_pkg.sv
// Shared types and constants for the instruction cache responder.
package icache_responder_pkg;

    // Refill controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } icache_state_t;

    localparam int          ICACHE_LINES      = 4;
    localparam int          ICACHE_LINE_WORDS = 4;
    localparam logic [31:0] NOP_INST          = 32'h0000_0013;

    // Field widths for the default geometry (32-bit address and instruction).
    localparam int ICACHE_DEF_TAG_W  = 32 - $clog2(ICACHE_LINES) - $clog2(ICACHE_LINE_WORDS) - 2;
    localparam int ICACHE_DEF_LINE_W = ICACHE_LINE_WORDS * 32;

    // One cache line as held in the tag/data array.
    typedef struct packed {
        logic                         valid;
        logic [ICACHE_DEF_TAG_W-1:0]  tag;
        logic [ICACHE_DEF_LINE_W-1:0] data;
    } icache_line_t;

endpackage

// File: rtl/icache_responder_tag_data_array.sv
// Tag/data storage: combinational read, single write port, flash-clear of valids.
module icache_tag_data_array #(
    parameter int NUM_LINES = 4,
    parameter int TAG_W     = 26,
    parameter int LINE_W    = 128,
    localparam int IDX_W    = $clog2(NUM_LINES)
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_clr_all,
    input  logic              i_we,
    input  logic              i_set_valid,
    input  logic [IDX_W-1:0]  i_w_idx,
    input  logic [TAG_W-1:0]  i_w_tag,
    input  logic [LINE_W-1:0] i_w_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [LINE_W-1:0] o_rd_data
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];

    // Valid bits: cleared by reset or flush; a write that is not cancelled by a flush sets one.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else begin
            if (i_clr_all) begin
                r_valid <= '0;
            end
            if (i_we && i_set_valid) begin
                r_valid[i_w_idx] <= 1'b1;
            end
        end
    end

    // Tag and data are plain storage; their contents only matter once the valid bit is set.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_w_idx]  <= i_w_tag;
            r_data[i_w_idx] <= i_w_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache answering fetch lookups and refilling lines from memory.
//
// state | meaning
// IDLE  | lookups served; a miss captures the line address and starts a refill
// REQ   | refill request held on the memory port until accepted
// WAIT  | waiting for the line; the response writes it and returns to IDLE
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int ADDR_LEN   = 32,
    parameter int INST_LEN   = 32,
    parameter int NUM_LINES  = ICACHE_LINES,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fet_req_valid,
    input  logic [ADDR_LEN-1:0]            fet_req_pc,
    output logic [INST_LEN-1:0]            fet_inst_out,
    output logic                           fet_hit_out,
    output logic                           stall_fet_out,
    input  logic                           flush_in,
    output logic                           mem_req_valid,
    output logic [ADDR_LEN-1:0]            mem_req_addr,
    input  logic                           mem_req_ready,
    input  logic                           mem_resp_valid,
    input  logic [LINE_WORDS*INST_LEN-1:0] mem_resp_data
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int LOW_W  = OFF_W + 2;
    localparam int TAG_W  = ADDR_LEN - IDX_W - LOW_W;
    localparam int LINE_W = LINE_WORDS * INST_LEN;

    icache_state_t       r_state;
    logic                r_mem_req_valid;
    logic [ADDR_LEN-1:0] r_miss_addr;
    logic                r_flush_pending;

    logic [OFF_W-1:0]    w_off;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_line_valid;
    logic [TAG_W-1:0]    w_line_tag;
    logic [LINE_W-1:0]   w_line_data;
    logic [INST_LEN-1:0] w_word;
    logic                w_hit;
    logic                w_miss;
    logic                w_fill;
    logic                w_flush_at_fill;
    logic                w_clr_all;
    logic [1:0]          w_unused_pc_bits;

    assign w_off            = fet_req_pc[LOW_W-1:2];
    assign w_idx            = fet_req_pc[LOW_W +: IDX_W];
    assign w_tag            = fet_req_pc[ADDR_LEN-1:LOW_W+IDX_W];
    assign w_unused_pc_bits = fet_req_pc[1:0];

    assign w_hit  = fet_req_valid && (r_state == IDLE) && w_line_valid && (w_line_tag == w_tag);
    assign w_miss = fet_req_valid && (r_state == IDLE) && !w_hit;
    assign w_fill = (r_state == WAIT) && mem_resp_valid;

    // A flush arriving on the fill edge itself cancels the fill just like an earlier one.
    assign w_flush_at_fill = r_flush_pending || flush_in;
    assign w_clr_all       = ((r_state == IDLE) && flush_in) || (w_fill && w_flush_at_fill);

    icache_tag_data_array #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W),
        .LINE_W    (LINE_W)
    ) u_array (
        .clk         (clk),
        .i_rst       (rst),
        .i_clr_all   (w_clr_all),
        .i_we        (w_fill),
        .i_set_valid (!w_flush_at_fill),
        .i_w_idx     (r_miss_addr[LOW_W +: IDX_W]),
        .i_w_tag     (r_miss_addr[ADDR_LEN-1:LOW_W+IDX_W]),
        .i_w_data    (mem_resp_data),
        .i_rd_idx    (w_idx),
        .o_rd_valid  (w_line_valid),
        .o_rd_tag    (w_line_tag),
        .o_rd_data   (w_line_data)
    );

    // Word select within the addressed line.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (w_off == OFF_W'(i)) begin
                w_word = w_line_data[i*INST_LEN +: INST_LEN];
            end
        end
    end

    assign fet_hit_out   = w_hit;
    assign fet_inst_out  = w_hit ? w_word : INST_LEN'(NOP_INST);
    assign stall_fet_out = (fet_req_valid && !w_hit) || (r_state != IDLE);
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_miss_addr;

    // Refill sequencer with registered memory request and deferred-flush tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_mem_req_valid <= 1'b0;
            r_miss_addr     <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_state         <= REQ;
                        r_mem_req_valid <= 1'b1;
                        r_miss_addr     <= {fet_req_pc[ADDR_LEN-1:LOW_W], {LOW_W{1'b0}}};
                    end
                end
                REQ: begin
                    if (flush_in) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        r_state         <= WAIT;
                        r_mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        r_state         <= IDLE;
                        r_flush_pending <= 1'b0;
                    end else if (flush_in) begin
                        r_flush_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state         <= IDLE;
                    r_mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: hand-computed lines and cycle-level miss timing.
module tb_icache_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         fet_req_valid;
    logic [31:0]  fet_req_pc;
    logic [31:0]  fet_inst_out;
    logic         fet_hit_out;
    logic         stall_fet_out;
    logic         flush_in;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [127:0] L0 = 128'h00000014_00000013_00000012_00000011;
    localparam logic [127:0] L4 = 128'h00000024_00000023_00000022_00000021;
    localparam logic [127:0] L1 = 128'h00000034_00000033_00000032_00000031;
    localparam logic [127:0] L2 = 128'h00000044_00000043_00000042_00000041;
    localparam logic [31:0]  NOP = 32'h0000_0013;

    icache_responder dut (
        .clk            (clk),
        .rst            (rst),
        .fet_req_valid  (fet_req_valid),
        .fet_req_pc     (fet_req_pc),
        .fet_inst_out   (fet_inst_out),
        .fet_hit_out    (fet_hit_out),
        .stall_fet_out  (stall_fet_out),
        .flush_in       (flush_in),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 2 time units past the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Serve one refill: wait for the request, hold off acceptance, then respond with a line.
    task automatic refill(input logic [31:0] exp_addr, input logic [127:0] line, input int hold);
        int n = 0;
        while (!mem_req_valid && n < 10) begin
            step();
            n++;
        end
        chk_val("req_seen", 32'(mem_req_valid), 32'd1);
        chk_val("req_addr", mem_req_addr, exp_addr);
        for (int i = 0; i < hold; i++) begin
            step();
            chk_val("bp_valid", 32'(mem_req_valid), 32'd1);
            chk_val("bp_addr", mem_req_addr, exp_addr);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        #1;
        chk_val("accept_drop", 32'(mem_req_valid), 32'd0);
        step();
        chk_val("single_accept", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = line;
        step();
        mem_resp_valid = 1'b0;
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic hit, input logic [31:0] inst);
        fet_req_valid = 1'b1;
        fet_req_pc    = pc;
        #1;
        chk_val({tag, "_hit"}, 32'(fet_hit_out), 32'(hit));
        chk_val({tag, "_inst"}, fet_inst_out, inst);
        chk_val({tag, "_stall"}, 32'(stall_fet_out), 32'(!hit));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        fet_req_valid  = 1'b0;
        fet_req_pc     = '0;
        flush_in       = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk_val("rst_hit", 32'(fet_hit_out), 32'd0);
        chk_val("rst_stall", 32'(stall_fet_out), 32'd0);
        chk_val("rst_mreq", 32'(mem_req_valid), 32'd0);
        chk_val("rst_maddr", mem_req_addr, 32'd0);

        // Cold miss with exact timing: detect at c0, accept at c1, respond at c5, hit at c6.
        mem_req_ready = 1'b1;
        lookup("c0", 32'h0, 1'b0, NOP);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 2) mem_req_ready = 1'b0;
            if (c == 5) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = L0;
            end
            #1;
            chk_val($sformatf("cold_stall_c%0d", c), 32'(stall_fet_out), 32'd1);
            chk_val($sformatf("cold_hit_c%0d", c), 32'(fet_hit_out), 32'd0);
            if (c == 1) begin
                chk_val("cold_mreq", 32'(mem_req_valid), 32'd1);
                chk_val("cold_maddr", mem_req_addr, 32'h0);
            end
            if (c == 3) chk_val("cold_wait_mreq", 32'(mem_req_valid), 32'd0);
        end
        step();
        mem_resp_valid = 1'b0;
        lookup("c6_pc00", 32'h00, 1'b1, 32'h11);
        lookup("pc04", 32'h04, 1'b1, 32'h12);
        lookup("pc08", 32'h08, 1'b1, 32'h13);
        lookup("pc0c", 32'h0C, 1'b1, 32'h14);

        // Flush and a conflicting miss in the same IDLE cycle: the refill still starts.
        fet_req_pc = 32'h40;
        flush_in   = 1'b1;
        #1;
        chk_val("flmiss_stall", 32'(stall_fet_out), 32'd1);
        step();
        flush_in = 1'b0;
        refill(32'h40, L4, 0);
        lookup("pc44", 32'h44, 1'b1, 32'h22);
        lookup("pc00_conflict", 32'h00, 1'b0, NOP);
        refill(32'h00, L0, 0);
        lookup("pc00_back", 32'h00, 1'b1, 32'h11);
        lookup("pc40_evicted", 32'h40, 1'b0, NOP);
        lookup("pc0c_again", 32'h0C, 1'b1, 32'h14);

        // Backpressure: request held five extra cycles, one acceptance.
        lookup("pc10_miss", 32'h10, 1'b0, NOP);
        refill(32'h10, L1, 5);
        lookup("pc1c", 32'h1C, 1'b1, 32'h34);

        // Flush in IDLE clears every line.
        fet_req_valid = 1'b0;
        flush_in      = 1'b1;
        step();
        flush_in = 1'b0;
        lookup("pc10_flushed", 32'h10, 1'b0, NOP);

        // Flush during WAIT: the fill completes but nothing is validated.
        lookup("pc20_miss", 32'h20, 1'b0, NOP);
        step();
        chk_val("fw_mreq", 32'(mem_req_valid), 32'd1);
        chk_val("fw_maddr", mem_req_addr, 32'h20);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        flush_in      = 1'b1;
        step();
        flush_in = 1'b0;
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = L2;
        step();
        mem_resp_valid = 1'b0;
        fet_req_valid  = 1'b0;
        #1;
        chk_val("fw_idle_stall", 32'(stall_fet_out), 32'd0);
        lookup("pc20_after_fw", 32'h20, 1'b0, NOP);
        lookup("pc00_after_fw", 32'h00, 1'b0, NOP);

        // Reset while waiting for a line, then a stray response in IDLE.
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        fet_req_valid = 1'b0;
        #1;
        chk_val("rm_wait_stall", 32'(stall_fet_out), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk_val("rm_stall", 32'(stall_fet_out), 32'd0);
        chk_val("rm_mreq", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = L0;
        step();
        mem_resp_valid = 1'b0;
        #1;
        chk_val("rm_stray_mreq", 32'(mem_req_valid), 32'd0);
        chk_val("rm_stray_stall", 32'(stall_fet_out), 32'd0);
        lookup("pc00_after_rst", 32'h00, 1'b0, NOP);

        // Stray response with nothing outstanding.
        fet_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = L2;
        step();
        mem_resp_valid = 1'b0;
        #1;
        chk_val("stray_mreq", 32'(mem_req_valid), 32'd0);
        chk_val("stray_stall", 32'(stall_fet_out), 32'd0);
        lookup("pc30_stray", 32'h30, 1'b0, NOP);
        fet_req_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
# icache_responder

Direct-mapped instruction cache acting as the responder end of the fetch-side instruction request. It sits between `fetch_stage` (initiator) and `main_memory` (line refill source). Hits return the instruction combinationally in the request cycle. Misses raise `stall_fet_out`, run a line refill over the memory request/response handshake, then resume so the retried request hits.

## Interface
Parameters:
- `ADDR_LEN`, 32, byte-address width
- `INST_LEN`, 32, instruction width (from `constants_pkg`)
- `NUM_LINES`, 4, cache lines; power of two, ≥2
- `LINE_WORDS`, 4, instructions per line; power of two; line = `LINE_WORDS*INST_LEN` bits

Ports (one clock; reset is synchronous, active-high):
- `clk` in 1: clock, rising edge
- `rst` in 1: synchronous active-high reset
- `fet_req_valid` in 1: fetch presents a PC this cycle
- `fet_req_pc` in ADDR_LEN: fetch PC; bits [1:0] ignored
- `fet_inst_out` out INST_LEN: instruction for `fet_req_pc`; valid when `fet_hit_out`=1
- `fet_hit_out` out 1: lookup hit this cycle
- `stall_fet_out` out 1: `fet_req_valid & ~fet_hit_out`, or state≠IDLE
- `flush_in` in 1: invalidate all lines (fence.i / kill)
- `mem_req_valid` out 1: line refill request
- `mem_req_addr` out ADDR_LEN: line-aligned refill address
- `mem_req_ready` in 1: memory accepts request
- `mem_resp_valid` in 1: refill data valid, single-cycle pulse
- `mem_resp_data` in LINE_WORDS*INST_LEN: full line; word 0 in LSBs

## Operation
- Address split: word offset `[log2(LINE_WORDS)+1:2]`; index = next `log2(NUM_LINES)` bits; tag = remaining upper bits.
- Storage per line: valid bit, tag, data. Data and tag are not reset; valid bits clear on `rst`.
- Hit = `fet_req_valid` & state==IDLE & valid[index] & tag match. `fet_inst_out` = selected word. On a miss `fet_inst_out` = NOP (`0x00000013`).
- FSM states: IDLE, REQ, WAIT.
  - IDLE → REQ on a miss. Capture the line-aligned PC into `miss_addr`.
  - REQ: `mem_req_valid`=1, `mem_req_addr`=`miss_addr`. Go to WAIT when `mem_req_ready`=1.
  - WAIT: on `mem_resp_valid`, write data and tag into line `miss_addr.index`, set valid (unless a flush is pending), then go to IDLE.
- Fetch holds `fet_req_pc` stable while `stall_fet_out`=1. The refill uses `miss_addr` only.
- Flush:
  - In IDLE: clear all valid bits at the clock edge.
  - In REQ/WAIT: set `flush_pending`. The refill completes but the line is not validated. At the fill edge, all valids clear and `flush_pending` clears.
  - `flush_in` and a miss in the same IDLE cycle: flush applies and the miss still starts a refill.
- `rst` mid-refill: return to IDLE, clear valids and `flush_pending`, drop `mem_req_valid`. A later stray `mem_resp_valid` in IDLE is ignored.

## Timing
- Reset values: state IDLE; `mem_req_valid`=0; `mem_req_addr`=0; all valid=0; `flush_pending`=0. `fet_hit_out`=0 and `stall_fet_out`=`fet_req_valid` after reset.
- Hit latency 0: combinational from `fet_req_pc` to `fet_inst_out`/`fet_hit_out`.
- Miss penalty: detect cycle N; REQ from N+1 (one cycle if ready); WAIT; fill edge at response cycle R; retried lookup hits at R+1. With ready and a response arriving k cycles after acceptance, the PC hits at cycle N+2+k.
- `mem_req_valid` is registered. It stays high with a stable address until `mem_req_ready`.
- `mem_resp_valid` outside WAIT is ignored.

## Structure
- `structure_pkg` gets `icache_state_t` (IDLE/REQ/WAIT enum) and a `icache_line_t` struct (valid, tag, data).
- `constants_pkg` gets `ICACHE_LINES`, `ICACHE_LINE_WORDS` and `NOP_INST`.
- One sub-module, `icache_tag_data_array`: storage with combinational read port and single write port, plus flash-clear of valids.

## Test plan
- Cold miss: reset, fetch PC 0x00, memory ready, response 3 cycles later with words 0x11..0x14 → stall high cycles 0–5, hit at cycle 6 with `fet_inst_out`=0x11. Next PCs 0x04/0x08/0x0C hit with 0x12/0x13/0x14, no stall.
- Conflict: fill 0x00, then fetch 0x40 (same index, NUM_LINES=4) → miss and refill. Return to 0x00 → miss again.
- Backpressure: `mem_req_ready` low 5 cycles → `mem_req_valid`/`mem_req_addr` stable 5 cycles, single acceptance.
- Flush during WAIT: miss on 0x20, assert `flush_in` in WAIT, respond → FSM returns to IDLE but 0x20 misses again; previously filled 0x00 also misses.
- Reset mid-refill: `rst` in WAIT, then `mem_resp_valid` pulse in IDLE → no line validated, `mem_req_valid`=0, fetch of 0x00 misses.
- Stray response: `mem_resp_valid` in IDLE with no request → no state change, no valid bit set.
